// File: rtl/execute_writeback_buffer_if.sv
// rtl/execute_writeback_buffer_if.sv - execute result, forwarding slot and register file commit bundle
// slave is the writeback buffer; master is the execute stage / register file side.
interface execute_writeback_buffer_if;
  logic        iEXE_VALID;
  logic        oEXE_BUSY;
  logic        iEXE_GR_VALID;
  logic [4:0]  iEXE_GR_DEST;
  logic        iEXE_GR_DEST_SYSREG;
  logic [31:0] iEXE_GR_DATA;
  logic        iEXE_SPR_VALID;
  logic [31:0] iEXE_SPR_DATA;

  logic        oWB_GR_VALID;
  logic [4:0]  oWB_GR_DEST;
  logic        oWB_GR_DEST_SYSREG;
  logic [31:0] oWB_GR_DATA;
  logic        oWB_SPR_VALID;
  logic [31:0] oWB_SPR_DATA;

  logic        oPREV_WB_GR_VALID;
  logic [4:0]  oPREV_WB_GR_DEST;
  logic        oPREV_WB_GR_DEST_SYSREG;
  logic [31:0] oPREV_WB_GR_DATA;
  logic        oPREV_WB_SPR_VALID;
  logic [31:0] oPREV_WB_SPR_DATA;

  logic        oRF_VALID;
  logic        iRF_BUSY;
  logic        oRF_GR_WE;
  logic [4:0]  oRF_GR_DEST;
  logic        oRF_GR_DEST_SYSREG;
  logic [31:0] oRF_GR_DATA;
  logic        oRF_SPR_WE;
  logic [31:0] oRF_SPR_DATA;
  logic [1:0]  oPENDING;

  modport slave (
    input  iEXE_VALID, iEXE_GR_VALID, iEXE_GR_DEST, iEXE_GR_DEST_SYSREG, iEXE_GR_DATA,
           iEXE_SPR_VALID, iEXE_SPR_DATA, iRF_BUSY,
    output oEXE_BUSY,
           oWB_GR_VALID, oWB_GR_DEST, oWB_GR_DEST_SYSREG, oWB_GR_DATA, oWB_SPR_VALID, oWB_SPR_DATA,
           oPREV_WB_GR_VALID, oPREV_WB_GR_DEST, oPREV_WB_GR_DEST_SYSREG, oPREV_WB_GR_DATA,
           oPREV_WB_SPR_VALID, oPREV_WB_SPR_DATA,
           oRF_VALID, oRF_GR_WE, oRF_GR_DEST, oRF_GR_DEST_SYSREG, oRF_GR_DATA, oRF_SPR_WE,
           oRF_SPR_DATA, oPENDING
  );

  modport master (
    output iEXE_VALID, iEXE_GR_VALID, iEXE_GR_DEST, iEXE_GR_DEST_SYSREG, iEXE_GR_DATA,
           iEXE_SPR_VALID, iEXE_SPR_DATA, iRF_BUSY,
    input  oEXE_BUSY,
           oWB_GR_VALID, oWB_GR_DEST, oWB_GR_DEST_SYSREG, oWB_GR_DATA, oWB_SPR_VALID, oWB_SPR_DATA,
           oPREV_WB_GR_VALID, oPREV_WB_GR_DEST, oPREV_WB_GR_DEST_SYSREG, oPREV_WB_GR_DATA,
           oPREV_WB_SPR_VALID, oPREV_WB_SPR_DATA,
           oRF_VALID, oRF_GR_WE, oRF_GR_DEST, oRF_GR_DEST_SYSREG, oRF_GR_DATA, oRF_SPR_WE,
           oRF_SPR_DATA, oPENDING
  );
endinterface

// File: rtl/execute_writeback_buffer.sv
// rtl/execute_writeback_buffer.sv - WB/PREV_WB forwarding slots plus register file commit queue
// EXECUTE_WB_QUEUE_EN selects the 2-entry commit queue; otherwise a single output register.
module execute_writeback_buffer (
  input logic                      iCLOCK,
  input logic                      iRESET,
  input logic                      iRESET_SYNC,
  execute_writeback_buffer_if.slave bus
);

  typedef struct packed {
    logic        gr_valid;
    logic [4:0]  gr_dest;
    logic        gr_sysreg;
    logic [31:0] gr_data;
    logic        spr_valid;
    logic [31:0] spr_data;
  } wb_entry_t;

  wb_entry_t incoming, wb_q, prev_q, head;
  logic      accept, wb_accept, pop, busy, head_valid;
  logic [1:0] pending;

  assign incoming  = {bus.iEXE_GR_VALID, bus.iEXE_GR_DEST, bus.iEXE_GR_DEST_SYSREG,
                      bus.iEXE_GR_DATA, bus.iEXE_SPR_VALID, bus.iEXE_SPR_DATA};
  assign accept    = bus.iEXE_VALID && !busy;
  assign wb_accept = accept && (bus.iEXE_GR_VALID || bus.iEXE_SPR_VALID);
  assign pop       = head_valid && !bus.iRF_BUSY;

  // Forwarding slots only move on a real writeback; queue drain leaves them alone.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wb_q   <= '0;
      prev_q <= '0;
    end else if (iRESET_SYNC) begin
      wb_q   <= '0;
      prev_q <= '0;
    end else if (wb_accept) begin
      prev_q <= wb_q;
      wb_q   <= incoming;
    end
  end

`ifdef EXECUTE_WB_QUEUE_EN
  wb_entry_t  mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (iRESET_SYNC) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wb_accept) begin
        mem[wr_ptr] <= incoming;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({wb_accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  assign head       = head_valid ? mem[rd_ptr] : '0;
  assign busy       = (count == 2'd2);
  assign pending    = count;
`else
  wb_entry_t hold_q;
  logic      hold_valid;

  // A new result may replace the held entry in the same cycle it is popped.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (iRESET_SYNC) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (wb_accept) begin
      hold_q     <= incoming;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign head_valid = hold_valid;
  assign head       = hold_valid ? hold_q : '0;
  assign busy       = hold_valid && bus.iRF_BUSY;
  assign pending    = {1'b0, hold_valid};
`endif

  assign bus.oEXE_BUSY = busy;
  assign bus.oPENDING  = pending;

  assign bus.oWB_GR_VALID       = wb_q.gr_valid;
  assign bus.oWB_GR_DEST        = wb_q.gr_dest;
  assign bus.oWB_GR_DEST_SYSREG = wb_q.gr_sysreg;
  assign bus.oWB_GR_DATA        = wb_q.gr_data;
  assign bus.oWB_SPR_VALID      = wb_q.spr_valid;
  assign bus.oWB_SPR_DATA       = wb_q.spr_data;

  assign bus.oPREV_WB_GR_VALID       = prev_q.gr_valid;
  assign bus.oPREV_WB_GR_DEST        = prev_q.gr_dest;
  assign bus.oPREV_WB_GR_DEST_SYSREG = prev_q.gr_sysreg;
  assign bus.oPREV_WB_GR_DATA        = prev_q.gr_data;
  assign bus.oPREV_WB_SPR_VALID      = prev_q.spr_valid;
  assign bus.oPREV_WB_SPR_DATA       = prev_q.spr_data;

  assign bus.oRF_VALID          = head_valid;
  assign bus.oRF_GR_WE          = head.gr_valid;
  assign bus.oRF_GR_DEST        = head.gr_dest;
  assign bus.oRF_GR_DEST_SYSREG = head.gr_sysreg;
  assign bus.oRF_GR_DATA        = head.gr_data;
  assign bus.oRF_SPR_WE         = head.spr_valid;
  assign bus.oRF_SPR_DATA       = head.spr_data;

endmodule

// File: tb/tb_execute_writeback_buffer.sv
// tb/tb_execute_writeback_buffer.sv - directed self-checking bench for execute_writeback_buffer
// Expectations follow EXECUTE_WB_QUEUE_EN where the queue depth changes behaviour.
module tb_execute_writeback_buffer;
  logic clk;
  logic rst;
  logic rst_sync;
  int   checks;
  int   errors;

  execute_writeback_buffer_if bus();

  execute_writeback_buffer dut (
    .iCLOCK      (clk),
    .iRESET      (rst),
    .iRESET_SYNC (rst_sync),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic gv, input logic [4:0] dest, input logic sys,
                       input logic [31:0] gd, input logic sv, input logic [31:0] sd);
    bus.iEXE_VALID          = 1'b1;
    bus.iEXE_GR_VALID       = gv;
    bus.iEXE_GR_DEST        = dest;
    bus.iEXE_GR_DEST_SYSREG = sys;
    bus.iEXE_GR_DATA        = gd;
    bus.iEXE_SPR_VALID      = sv;
    bus.iEXE_SPR_DATA       = sd;
  endtask

  task automatic idle();
    offer(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.iEXE_VALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    rst_sync = 1'b0;
    bus.iRF_BUSY = 1'b0;
    idle();
    #12;
    check("rst_rf_valid", bus.oRF_VALID, 0);
    check("rst_pending", bus.oPENDING, 0);
    check("rst_busy", bus.oEXE_BUSY, 0);
    check("rst_wb_valid", bus.oWB_GR_VALID, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back GR writes with free register file.
    offer(1'b1, 5'd3, 1'b0, 32'h11, 1'b0, 32'h0);
    tick();
    check("b2b_wb_dest1", bus.oWB_GR_DEST, 3);
    check("b2b_wb_data1", bus.oWB_GR_DATA, 32'h11);
    check("b2b_prev_v1", bus.oPREV_WB_GR_VALID, 0);
    check("b2b_rf_valid1", bus.oRF_VALID, 1);
    check("b2b_rf_dest1", bus.oRF_GR_DEST, 3);
    check("b2b_rf_data1", bus.oRF_GR_DATA, 32'h11);
    offer(1'b1, 5'd4, 1'b0, 32'h22, 1'b0, 32'h0);
    tick();
    check("b2b_wb_dest2", bus.oWB_GR_DEST, 4);
    check("b2b_wb_data2", bus.oWB_GR_DATA, 32'h22);
    check("b2b_prev_v2", bus.oPREV_WB_GR_VALID, 1);
    check("b2b_prev_dest2", bus.oPREV_WB_GR_DEST, 3);
    check("b2b_prev_data2", bus.oPREV_WB_GR_DATA, 32'h11);
    check("b2b_rf_dest2", bus.oRF_GR_DEST, 4);
    check("b2b_pending2", bus.oPENDING, 1);
    idle();
    tick();
    check("drain_rf_valid", bus.oRF_VALID, 0);
    check("drain_rf_data", bus.oRF_GR_DATA, 0);
    check("drain_rf_we", bus.oRF_GR_WE, 0);
    check("drain_pending", bus.oPENDING, 0);
    check("drain_wb_kept", bus.oWB_GR_DATA, 32'h22);

    // Backpressure.
    bus.iRF_BUSY = 1'b1;
    offer(1'b1, 5'd5, 1'b0, 32'hA, 1'b0, 32'h0);
    tick();
    check("bp_pending_a", bus.oPENDING, 1);
    check("bp_head_a", bus.oRF_GR_DEST, 5);
`ifdef EXECUTE_WB_QUEUE_EN
    check("bp_busy_a", bus.oEXE_BUSY, 0);
    offer(1'b1, 5'd6, 1'b0, 32'hB, 1'b0, 32'h0);
    tick();
    check("bp_pending_b", bus.oPENDING, 2);
    check("bp_busy_b", bus.oEXE_BUSY, 1);
    offer(1'b1, 5'd7, 1'b0, 32'hC, 1'b0, 32'h0);
    tick();
    check("bp_held_pending", bus.oPENDING, 2);
    check("bp_held_head", bus.oRF_GR_DATA, 32'hA);
    check("bp_held_wb", bus.oWB_GR_DEST, 6);
    bus.iRF_BUSY = 1'b0;
    tick();
    check("bp_pop_a_head", bus.oRF_GR_DEST, 6);
    check("bp_pop_a_pending", bus.oPENDING, 1);
    check("bp_pop_a_busy", bus.oEXE_BUSY, 0);
    tick();
    check("bp_c_head", bus.oRF_GR_DEST, 7);
    check("bp_c_pending", bus.oPENDING, 1);
    check("bp_c_wb", bus.oWB_GR_DEST, 7);
    check("bp_c_prev", bus.oPREV_WB_GR_DEST, 6);
`else
    check("bp_busy_a", bus.oEXE_BUSY, 1);
    offer(1'b1, 5'd6, 1'b0, 32'hB, 1'b0, 32'h0);
    tick();
    check("bp_held_pending", bus.oPENDING, 1);
    check("bp_held_head", bus.oRF_GR_DATA, 32'hA);
    check("bp_held_wb", bus.oWB_GR_DEST, 5);
    bus.iRF_BUSY = 1'b0;
    #1;
    check("bp_busy_drop", bus.oEXE_BUSY, 0);
    tick();
    check("bp_swap_head", bus.oRF_GR_DEST, 6);
    check("bp_swap_pending", bus.oPENDING, 1);
    check("bp_swap_wb", bus.oWB_GR_DEST, 6);
    check("bp_swap_prev", bus.oPREV_WB_GR_DEST, 5);
`endif
    idle();
    tick();
    check("bp_drained", bus.oPENDING, 0);

    // SPR, sysreg and non-writeback accepts.
    offer(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h8000);
    tick();
    check("spr_wb_valid", bus.oWB_SPR_VALID, 1);
    check("spr_wb_data", bus.oWB_SPR_DATA, 32'h8000);
    check("spr_wb_gr", bus.oWB_GR_VALID, 0);
    check("spr_rf_we", bus.oRF_SPR_WE, 1);
    check("spr_rf_data", bus.oRF_SPR_DATA, 32'h8000);
    offer(1'b1, 5'd1, 1'b1, 32'h1234, 1'b0, 32'h0);
    tick();
    check("sys_wb_flag", bus.oWB_GR_DEST_SYSREG, 1);
    check("sys_rf_flag", bus.oRF_GR_DEST_SYSREG, 1);
    check("sys_prev_spr", bus.oPREV_WB_SPR_VALID, 1);
    offer(1'b0, 5'd9, 1'b0, 32'hDEAD, 1'b0, 32'hBEEF);
    tick();
    check("nowb_wb_data", bus.oWB_GR_DATA, 32'h1234);
    check("nowb_prev_spr", bus.oPREV_WB_SPR_DATA, 32'h8000);
    check("nowb_pending", bus.oPENDING, 0);

    // Asynchronous reset mid-traffic.
    bus.iRF_BUSY = 1'b1;
    offer(1'b1, 5'd8, 1'b0, 32'hD, 1'b0, 32'h0);
    tick();
    offer(1'b1, 5'd9, 1'b0, 32'hE, 1'b0, 32'h0);
    tick();
`ifdef EXECUTE_WB_QUEUE_EN
    check("pre_rst_pending", bus.oPENDING, 2);
`else
    check("pre_rst_pending", bus.oPENDING, 1);
`endif
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("arst_pending", bus.oPENDING, 0);
    check("arst_rf_valid", bus.oRF_VALID, 0);
    check("arst_rf_data", bus.oRF_GR_DATA, 0);
    check("arst_busy", bus.oEXE_BUSY, 0);
    check("arst_wb_valid", bus.oWB_GR_VALID, 0);
    check("arst_wb_data", bus.oWB_GR_DATA, 0);
    check("arst_prev_valid", bus.oPREV_WB_GR_VALID, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.iRF_BUSY = 1'b0;

    // Synchronous clear drops a same-cycle accept.
    rst_sync = 1'b1;
    offer(1'b1, 5'd10, 1'b0, 32'hF, 1'b0, 32'h0);
    tick();
    check("srst_wb_valid", bus.oWB_GR_VALID, 0);
    check("srst_pending", bus.oPENDING, 0);
    rst_sync = 1'b0;
    offer(1'b1, 5'd11, 1'b0, 32'h77, 1'b0, 32'h0);
    tick();
    check("post_rst_wb_dest", bus.oWB_GR_DEST, 11);
    check("post_rst_wb_data", bus.oWB_GR_DATA, 32'h77);
    check("post_rst_prev", bus.oPREV_WB_GR_VALID, 0);
    check("post_rst_rf", bus.oRF_VALID, 1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
